sd_cmd_engine: RTL and testbench

Parametrised successor to the SD host command/data sequencing layer, sitting between the wishbone-facing SD host controller and the SD PHY. Adds four behaviours to that layer: response and data timeouts, automatic command reissue on response CRC failure, busy-wait for R1b responses, and multi-block data transfers with a block counter. Issues 48-bit-framed commands (40 payload bits) to the PHY and collects 40/136-bit responses. Drives per-block data activation to the data PHY.

---
 rtl/sd_cmd_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD host command/data sequencing layer.
// Command side issues a framed command to the PHY, retries on response CRC
// failure, optionally waits out card busy, and reports timeouts. Data side
// sequences per-block activation to the data PHY with a block counter.
module sd_cmd_engine #(
  parameter int TIMEOUT_W   = 16,
  parameter int MAX_RETRY   = 3,
  parameter int BLOCK_CNT_W = 16,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_crc_enable_flag,
  input  logic [TIMEOUT_W-1:0]   i_timeout,
  input  logic                   i_cmd_en,
  input  logic [5:0]             i_cmd,
  input  logic [31:0]            i_cmd_arg,
  input  logic [1:0]             i_rsp_type,
  output logic                   o_cmd_finished_en,
  output logic [7:0]             o_error,
  output logic                   o_rsp_stb,
  output logic [127:0]           o_rsp,
  output logic [RW-1:0]          o_retry_count,
  output logic                   o_phy_cmd_en,
  output logic [39:0]            o_phy_cmd,
  output logic [7:0]             o_phy_rsp_len,
  input  logic                   i_phy_rsp_finished_en,
  input  logic [135:0]           i_phy_rsp,
  input  logic                   i_phy_crc_bad,
  input  logic                   i_phy_busy,
  input  logic                   i_data_txrx,
  input  logic                   i_data_write_flag,
  input  logic [BLOCK_CNT_W-1:0] i_block_count,
  input  logic [11:0]            i_block_size,
  output logic                   o_data_txrx_activate,
  input  logic                   i_data_txrx_finished,
  input  logic                   i_data_crc_read_err,
  output logic [BLOCK_CNT_W-1:0] o_data_block_done,
  output logic                   o_data_txrx_finished,
  output logic [7:0]             o_data_error,
  output logic                   o_error_flag,
  output logic [11:0]            o_data_byte_count,
  output logic                   o_data_write_flag
);

  typedef enum logic [2:0] {C_IDLE, C_WAIT_RSP, C_RETRY, C_WAIT_BUSY, C_FINISHED} cst_e;
  typedef enum logic [1:0] {D_IDLE, D_ACTIVATE, D_WAIT, D_FINISHED} dst_e;

  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);

  cst_e                   cst_q;
  dst_e                   dst_q;
  logic [TIMEOUT_W-1:0]   ccnt_q, dcnt_q, tmo_m1;
  logic [RW-1:0]          retry_q;
  logic                   busy_type_q;
  logic                   phy_en_q, fin_q, stb_q, act_q, dfin_q, eflag_q;
  logic [7:0]             err_q, err_d, derr_q, derr_d, len_q;
  logic [39:0]            phy_cmd_q;
  logic [127:0]           rsp_q;
  logic [BLOCK_CNT_W-1:0] done_q, done_inc, eff_cnt;
  logic                   c_tmo_hit, d_tmo_hit;
  logic                   c_accept, c_rsp, c_crcf, c_retry, c_rtmo, c_btmo;
  logic                   d_start, d_fin, d_tmo;
  logic                   unused_rsp_hi;

  // A wait expires on the cycle whose count reaches i_timeout (0 = never).
  assign tmo_m1    = i_timeout - TIMEOUT_W'(1);
  assign c_tmo_hit = (i_timeout != '0) && (ccnt_q == tmo_m1);
  assign d_tmo_hit = (i_timeout != '0) && (dcnt_q == tmo_m1);

  // Command events; a low i_cmd_en masks everything since it forces IDLE.
  assign c_accept = (cst_q == C_IDLE) && i_cmd_en;
  assign c_rsp    = (cst_q == C_WAIT_RSP) && i_cmd_en && i_phy_rsp_finished_en;
  assign c_crcf   = i_phy_crc_bad && i_crc_enable_flag;
  assign c_retry  = c_rsp && c_crcf && (retry_q < MAXR);
  assign c_rtmo   = (cst_q == C_WAIT_RSP) && i_cmd_en && !i_phy_rsp_finished_en && c_tmo_hit;
  assign c_btmo   = (cst_q == C_WAIT_BUSY) && i_cmd_en && i_phy_busy && c_tmo_hit;

  // Data events; a zero block count behaves as a single block.
  assign eff_cnt  = (i_block_count == '0) ? BLOCK_CNT_W'(1) : i_block_count;
  assign done_inc = done_q + BLOCK_CNT_W'(1);
  assign d_start  = (dst_q == D_IDLE) && i_data_txrx;
  assign d_fin    = (dst_q == D_WAIT) && i_data_txrx && i_data_txrx_finished;
  assign d_tmo    = (dst_q == D_WAIT) && i_data_txrx && !i_data_txrx_finished && d_tmo_hit;

  // Next error codes, shared by the FSMs and the zero-lag error flag.
  always_comb begin
    err_d = err_q;
    if (c_accept)                         err_d = 8'h00;
    else if (c_rsp && !c_retry && c_crcf) err_d = 8'h01;
    else if (c_rtmo)                      err_d = 8'h02;
    else if (c_btmo)                      err_d = 8'h03;
    derr_d = derr_q;
    if (d_start)                          derr_d = 8'h00;
    else if (d_fin && i_data_crc_read_err) derr_d = 8'h04;
    else if (d_tmo)                       derr_d = 8'h05;
  end

  // Command FSM: issue, retry on CRC failure, optional busy wait, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst_q <= C_IDLE; ccnt_q <= '0; retry_q <= '0; busy_type_q <= 1'b0;
      phy_en_q <= 1'b0; fin_q <= 1'b0; stb_q <= 1'b0; err_q <= '0;
      len_q <= '0; phy_cmd_q <= '0; rsp_q <= '0;
    end else begin
      stb_q <= 1'b0;
      err_q <= err_d;
      if (!i_cmd_en) begin
        cst_q <= C_IDLE; phy_en_q <= 1'b0; fin_q <= 1'b0;
      end else begin
        case (cst_q)
          C_IDLE: begin
            phy_cmd_q   <= {2'b01, i_cmd, i_cmd_arg};
            busy_type_q <= (i_rsp_type == 2'b11);
            case (i_rsp_type)
              2'b00:   len_q <= 8'd0;
              2'b10:   len_q <= 8'd136;
              default: len_q <= 8'd40;
            endcase
            retry_q  <= '0;
            ccnt_q   <= '0;
            phy_en_q <= 1'b1;
            cst_q    <= C_WAIT_RSP;
          end
          C_WAIT_RSP: begin
            ccnt_q <= ccnt_q + TIMEOUT_W'(1);
            if (c_retry) begin
              retry_q  <= retry_q + RW'(1);
              phy_en_q <= 1'b0;
              cst_q    <= C_RETRY;
            end else if (i_phy_rsp_finished_en) begin
              rsp_q    <= i_phy_rsp[127:0];
              stb_q    <= 1'b1;
              phy_en_q <= 1'b0;
              ccnt_q   <= '0;
              cst_q    <= (busy_type_q && !c_crcf) ? C_WAIT_BUSY : C_FINISHED;
            end else if (c_tmo_hit) begin
              phy_en_q <= 1'b0;
              cst_q    <= C_FINISHED;
            end
          end
          C_RETRY: begin
            ccnt_q   <= '0;
            phy_en_q <= 1'b1;
            cst_q    <= C_WAIT_RSP;
          end
          C_WAIT_BUSY: begin
            ccnt_q <= ccnt_q + TIMEOUT_W'(1);
            if (!i_phy_busy || c_tmo_hit) cst_q <= C_FINISHED;
          end
          C_FINISHED: fin_q <= 1'b1;
          default:    cst_q <= C_IDLE;
        endcase
      end
    end
  end

  // Data FSM: one activate per block until the count, a CRC error or a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q <= D_IDLE; dcnt_q <= '0; act_q <= 1'b0; dfin_q <= 1'b0;
      done_q <= '0; derr_q <= '0;
    end else begin
      derr_q <= derr_d;
      if (!i_data_txrx) begin
        dst_q <= D_IDLE; act_q <= 1'b0; dfin_q <= 1'b0; done_q <= '0;
      end else begin
        case (dst_q)
          D_IDLE: begin
            done_q <= '0;
            dst_q  <= D_ACTIVATE;
          end
          D_ACTIVATE: begin
            act_q  <= 1'b1;
            dcnt_q <= '0;
            dst_q  <= D_WAIT;
          end
          D_WAIT: begin
            dcnt_q <= dcnt_q + TIMEOUT_W'(1);
            if (i_data_txrx_finished) begin
              act_q  <= 1'b0;
              done_q <= done_inc;
              if (!i_data_crc_read_err && (done_inc < eff_cnt)) dst_q <= D_ACTIVATE;
              else                                              dst_q <= D_FINISHED;
            end else if (d_tmo_hit) begin
              act_q <= 1'b0;
              dst_q <= D_FINISHED;
            end
          end
          D_FINISHED: dfin_q <= 1'b1;
          default:    dst_q  <= D_IDLE;
        endcase
      end
    end
  end

  // Error flag follows the next-state error codes so it lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eflag_q <= 1'b0;
    else        eflag_q <= (err_d != 8'h00) || (derr_d != 8'h00);
  end

  assign unused_rsp_hi        = ^i_phy_rsp[135:128];
  assign o_cmd_finished_en    = fin_q;
  assign o_error              = err_q;
  assign o_rsp_stb            = stb_q;
  assign o_rsp                = rsp_q;
  assign o_retry_count        = retry_q;
  assign o_phy_cmd_en         = phy_en_q;
  assign o_phy_cmd            = phy_cmd_q;
  assign o_phy_rsp_len        = len_q;
  assign o_data_txrx_activate = act_q;
  assign o_data_block_done    = done_q;
  assign o_data_txrx_finished = dfin_q;
  assign o_data_error         = derr_q;
  assign o_error_flag         = eflag_q;
  assign o_data_byte_count    = i_block_size;
  assign o_data_write_flag    = i_data_write_flag;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: expected responses, command
// completions and data completions are queued at stimulus time and popped by
// a monitor when the DUT produces them.
module tb_sd_cmd_engine;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         i_crc_enable_flag = 1'b1;
  logic [15:0]  i_timeout = '0;
  logic         i_cmd_en = 1'b0;
  logic [5:0]   i_cmd = '0;
  logic [31:0]  i_cmd_arg = '0;
  logic [1:0]   i_rsp_type = '0;
  logic         o_cmd_finished_en, o_rsp_stb, o_phy_cmd_en;
  logic [7:0]   o_error, o_phy_rsp_len, o_data_error;
  logic [127:0] o_rsp;
  logic [1:0]   o_retry_count;
  logic [39:0]  o_phy_cmd;
  logic         i_phy_rsp_finished_en = 1'b0, i_phy_crc_bad = 1'b0, i_phy_busy = 1'b0;
  logic [135:0] i_phy_rsp = '0;
  logic         i_data_txrx = 1'b0, i_data_write_flag = 1'b0;
  logic [15:0]  i_block_count = '0, o_data_block_done;
  logic [11:0]  i_block_size = '0, o_data_byte_count;
  logic         o_data_txrx_activate, o_data_txrx_finished, o_error_flag, o_data_write_flag;
  logic         i_data_txrx_finished = 1'b0, i_data_crc_read_err = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_engine dut (
    .clk(clk), .rst_n(rst_n), .i_crc_enable_flag(i_crc_enable_flag), .i_timeout(i_timeout),
    .i_cmd_en(i_cmd_en), .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsp_type(i_rsp_type),
    .o_cmd_finished_en(o_cmd_finished_en), .o_error(o_error), .o_rsp_stb(o_rsp_stb),
    .o_rsp(o_rsp), .o_retry_count(o_retry_count), .o_phy_cmd_en(o_phy_cmd_en),
    .o_phy_cmd(o_phy_cmd), .o_phy_rsp_len(o_phy_rsp_len),
    .i_phy_rsp_finished_en(i_phy_rsp_finished_en), .i_phy_rsp(i_phy_rsp),
    .i_phy_crc_bad(i_phy_crc_bad), .i_phy_busy(i_phy_busy), .i_data_txrx(i_data_txrx),
    .i_data_write_flag(i_data_write_flag), .i_block_count(i_block_count),
    .i_block_size(i_block_size), .o_data_txrx_activate(o_data_txrx_activate),
    .i_data_txrx_finished(i_data_txrx_finished), .i_data_crc_read_err(i_data_crc_read_err),
    .o_data_block_done(o_data_block_done), .o_data_txrx_finished(o_data_txrx_finished),
    .o_data_error(o_data_error), .o_error_flag(o_error_flag),
    .o_data_byte_count(o_data_byte_count), .o_data_write_flag(o_data_write_flag)
  );

  int n_chk = 0, n_fail = 0;
  logic [127:0] exp_rsp_q[$];
  logic [15:0]  exp_fin_q[$];   // {error, retry count}
  logic [23:0]  exp_dat_q[$];   // {blocks done, data error}
  int stb_cnt = 0, rise_cnt = 0, act_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: pops scoreboard entries as the DUT produces results.
  initial begin
    logic pfin, pphy, pdfin, pact;
    pfin = 0; pphy = 0; pdfin = 0; pact = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_rsp_stb) begin
          stb_cnt++;
          if (exp_rsp_q.size() == 0) chk("rsp_extra", 128'(exp_rsp_q.size()), 128'(1));
          else chk("rsp", o_rsp, exp_rsp_q.pop_front());
        end
        if (o_cmd_finished_en && !pfin) begin
          if (exp_fin_q.size() == 0) chk("fin_extra", 128'(exp_fin_q.size()), 128'(1));
          else chk("fin_err_retry", 128'({o_error, 8'(o_retry_count)}), 128'(exp_fin_q.pop_front()));
        end
        if (o_data_txrx_finished && !pdfin) begin
          if (exp_dat_q.size() == 0) chk("dat_extra", 128'(exp_dat_q.size()), 128'(1));
          else chk("dat_done_err", 128'({o_data_block_done, o_data_error}), 128'(exp_dat_q.pop_front()));
        end
        if (o_phy_cmd_en && !pphy) rise_cnt++;
        if (o_data_txrx_activate && !pact) act_cnt++;
      end
      pfin = o_cmd_finished_en; pphy = o_phy_cmd_en;
      pdfin = o_data_txrx_finished; pact = o_data_txrx_activate;
    end
  end

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t);
    @(negedge clk);
    i_cmd = c; i_cmd_arg = a; i_rsp_type = t; i_cmd_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_cmd(input logic [7:0] e);
    @(negedge clk); i_cmd_en = 1'b0;
    @(negedge clk);
    chk("rel_fin_low", 128'(o_cmd_finished_en), 128'(0));
    chk("rel_phy_low", 128'(o_phy_cmd_en), 128'(0));
    chk("rel_err_hold", 128'(o_error), 128'(e));
  endtask

  task automatic phy_rsp(input int dly, input logic bad, input logic cap);
    logic [135:0] r;
    repeat (dly) @(negedge clk);
    r = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    if (cap) exp_rsp_q.push_back(r[127:0]);
    i_phy_rsp = r; i_phy_crc_bad = bad; i_phy_rsp_finished_en = 1'b1;
    @(negedge clk);
    i_phy_rsp_finished_en = 1'b0; i_phy_crc_bad = 1'b0;
  endtask

  task automatic bad_retry();
    phy_rsp(4, 1'b1, 1'b0);
    chk("retry_gap_lo", 128'(o_phy_cmd_en), 128'(0));
    @(negedge clk);
    chk("retry_gap_hi", 128'(o_phy_cmd_en), 128'(1));
  endtask

  task automatic wait_fin(input int max);
    for (int i = 0; i < max && !o_cmd_finished_en; i++) @(negedge clk);
    chk("fin_seen", 128'(o_cmd_finished_en), 128'(1));
  endtask

  // Cycles until the selected event: 0 cmd error, 1 cmd finished, 2 data error.
  task automatic lat(input int sel, output int k);
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (sel == 0 && o_error != 0) break;
      if (sel == 1 && o_cmd_finished_en) break;
      if (sel == 2 && o_data_error != 0) break;
    end
  endtask

  task automatic data_run(input int cfg, input int crc_blk, input int nexp);
    int a0;
    a0 = act_cnt;
    exp_dat_q.push_back({16'(nexp), (crc_blk != 0) ? 8'h04 : 8'h00});
    i_block_count = 16'(cfg); i_block_size = 12'd512; i_data_write_flag = 1'b1;
    @(negedge clk); i_data_txrx = 1'b1;
    for (int b = 1; b <= nexp; b++) begin
      for (int i = 0; i < 10 && !o_data_txrx_activate; i++) @(negedge clk);
      chk("act_hi", 128'(o_data_txrx_activate), 128'(1));
      repeat (3) @(negedge clk);
      i_data_txrx_finished = 1'b1; i_data_crc_read_err = (b == crc_blk);
      @(negedge clk);
      i_data_txrx_finished = 1'b0; i_data_crc_read_err = 1'b0;
      chk("act_gap", 128'(o_data_txrx_activate), 128'(0));
      if (b < nexp) begin
        @(negedge clk);
        chk("act_back", 128'(o_data_txrx_activate), 128'(1));
      end
    end
    for (int i = 0; i < 10 && !o_data_txrx_finished; i++) @(negedge clk);
    chk("dfin", 128'(o_data_txrx_finished), 128'(1));
    chk("done", 128'(o_data_block_done), 128'(nexp));
    chk("bytes", 128'(o_data_byte_count), 128'(512));
    chk("wflag", 128'(o_data_write_flag), 128'(1));
    @(negedge clk);
    chk("act_cnt", 128'(act_cnt - a0), 128'(nexp));
    chk("no_extra_act", 128'(o_data_txrx_activate), 128'(0));
    i_data_txrx = 1'b0;
    @(negedge clk);
    chk("done_clr", 128'(o_data_block_done), 128'(0));
    chk("dfin_clr", 128'(o_data_txrx_finished), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, k;
    #1;
    chk("rst_phy_en", 128'(o_phy_cmd_en), 128'(0));
    chk("rst_err", 128'({o_error, o_data_error, 7'b0, o_error_flag}), 128'(0));
    chk("rst_act", 128'({o_data_txrx_activate, o_data_block_done}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Short response, CRC good.
    s0 = stb_cnt; r0 = rise_cnt;
    exp_fin_q.push_back({8'h00, 8'd0});
    issue(6'd17, 32'h0000_0200, 2'b01);
    chk("phy_cmd", 128'(o_phy_cmd), 128'(40'h51_0000_0200));
    chk("rsp_len", 128'(o_phy_rsp_len), 128'(40));
    chk("phy_en", 128'(o_phy_cmd_en), 128'(1));
    phy_rsp(10, 1'b0, 1'b1);
    chk("phy_en_off", 128'(o_phy_cmd_en), 128'(0));
    wait_fin(10);
    repeat (3) @(negedge clk);
    chk("fin_hold", 128'(o_cmd_finished_en), 128'(1));
    chk("stb_once", 128'(stb_cnt - s0), 128'(1));
    chk("issue_once", 128'(rise_cnt - r0), 128'(1));
    release_cmd(8'h00);

    // Retry: bad, bad, good.
    s0 = stb_cnt; r0 = rise_cnt;
    exp_fin_q.push_back({8'h00, 8'd2});
    issue(6'd18, 32'h0000_0400, 2'b01);
    bad_retry(); bad_retry();
    phy_rsp(4, 1'b0, 1'b1);
    wait_fin(10);
    chk("retry_rises", 128'(rise_cnt - r0), 128'(3));
    chk("retry_stb", 128'(stb_cnt - s0), 128'(1));
    release_cmd(8'h00);

    // Retries exhausted: four bad responses.
    exp_fin_q.push_back({8'h01, 8'd3});
    issue(6'd18, 32'h0000_0600, 2'b01);
    bad_retry(); bad_retry(); bad_retry();
    phy_rsp(4, 1'b1, 1'b1);
    wait_fin(10);
    chk("exh_retry", 128'(o_retry_count), 128'(3));
    chk("exh_flag", 128'(o_error_flag), 128'(1));
    release_cmd(8'h01);

    // Bad CRC with checking disabled is accepted without retry.
    i_crc_enable_flag = 1'b0;
    exp_fin_q.push_back({8'h00, 8'd0});
    issue(6'd13, 32'h1234_5678, 2'b10);
    chk("rsp_len_long", 128'(o_phy_rsp_len), 128'(136));
    phy_rsp(3, 1'b1, 1'b1);
    wait_fin(10);
    release_cmd(8'h00);
    i_crc_enable_flag = 1'b1;

    // Response timeout, T=20.
    i_timeout = 16'd20;
    exp_fin_q.push_back({8'h02, 8'd0});
    issue(6'd2, 32'h0, 2'b10);
    lat(0, k);
    chk("rtmo_lat", 128'(k), 128'(20));
    chk("rtmo_err", 128'(o_error), 128'(2));
    chk("rtmo_flag", 128'(o_error_flag), 128'(1));
    wait_fin(5);
    release_cmd(8'h02);

    // Busy wait: busy for 50 cycles after the response, T=100.
    i_timeout = 16'd100;
    exp_fin_q.push_back({8'h00, 8'd0});
    issue(6'd7, 32'h0001_0000, 2'b11);
    i_phy_busy = 1'b1;
    phy_rsp(5, 1'b0, 1'b1);
    chk("busy_phy_off", 128'(o_phy_cmd_en), 128'(0));
    repeat (49) @(negedge clk);
    chk("busy_wait", 128'(o_cmd_finished_en), 128'(0));
    i_phy_busy = 1'b0;
    lat(1, k);
    chk("busy_fin_lat", 128'(k), 128'(2));
    release_cmd(8'h00);

    // Busy timeout, T=30.
    i_timeout = 16'd30;
    exp_fin_q.push_back({8'h03, 8'd0});
    issue(6'd7, 32'h0001_0000, 2'b11);
    i_phy_busy = 1'b1;
    phy_rsp(5, 1'b0, 1'b1);
    lat(0, k);
    chk("btmo_lat", 128'(k), 128'(30));
    chk("btmo_err", 128'(o_error), 128'(3));
    wait_fin(5);
    i_phy_busy = 1'b0;
    release_cmd(8'h03);

    // Data: 4 blocks, CRC error on block 2, zero count as one block.
    i_timeout = 16'd0;
    data_run(4, 0, 4);
    data_run(4, 2, 2);
    data_run(0, 0, 1);

    // Data timeout, T=8.
    i_timeout = 16'd8;
    exp_dat_q.push_back({16'd0, 8'h05});
    i_block_count = 16'd2;
    @(negedge clk); i_data_txrx = 1'b1;
    for (int i = 0; i < 10 && !o_data_txrx_activate; i++) @(negedge clk);
    lat(2, k);
    chk("dtmo_lat", 128'(k), 128'(8));
    chk("dtmo_err", 128'(o_data_error), 128'(5));
    chk("dtmo_act", 128'(o_data_txrx_activate), 128'(0));
    repeat (2) @(negedge clk);
    i_data_txrx = 1'b0;
    @(negedge clk);

    // Async reset mid WAIT_RSP and mid data WAIT.
    i_timeout = 16'd0;
    issue(6'd17, 32'h0000_0200, 2'b01);
    i_block_count = 16'd4; i_data_txrx = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_phy", 128'(o_phy_cmd_en), 128'(1));
    chk("pre_rst_act", 128'(o_data_txrx_activate), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phy", 128'({o_phy_cmd_en, o_phy_cmd, o_phy_rsp_len}), 128'(0));
    chk("arst_rsp", o_rsp, 128'(0));
    chk("arst_cmd", 128'({o_cmd_finished_en, o_error, o_rsp_stb, o_retry_count, o_error_flag}), 128'(0));
    chk("arst_data", 128'({o_data_txrx_activate, o_data_block_done, o_data_txrx_finished, o_data_error}), 128'(0));
    i_cmd_en = 1'b0; i_data_txrx = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rsp_q_empty", 128'(exp_rsp_q.size()), 128'(0));
    chk("fin_q_empty", 128'(exp_fin_q.size()), 128'(0));
    chk("dat_q_empty", 128'(exp_dat_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
